// File: rtl/gpu_ctrl_pkg.sv
// Shared types and default sizing for the GPU frame-control blocks.
package gpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_BUFFER = 2'd1,
    LOAD_MATRIX = 2'd2,
    RUN         = 2'd3
  } sched_state_t;

  localparam int unsigned DEFAULT_FRAME_PERIOD = 2_000_000;
  localparam int unsigned DEFAULT_TIMER_W      = 22;
  localparam int unsigned DEFAULT_CNT_W        = 16;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period timer: counts while enabled, held at 0 otherwise,
// emits a registered one-cycle tick each time it wraps from FRAME_PERIOD-1.
module frame_timer
  import gpu_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
  parameter int unsigned TIMER_W      = DEFAULT_TIMER_W
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic enable_in,
  output logic tick_out
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(FRAME_PERIOD - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tick_q, tick_d;

  always_comb begin
    timer_d = '0;
    tick_d  = 1'b0;
    if (enable_in) begin
      if (timer_q == LAST) begin
        tick_d = 1'b1;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: buffer wait, matrix load, vertex-fetch release, end-of-frame detect.
// Pixel/frame statistics are built only when FRAME_STATS_EN is defined; otherwise tied to 0.
module frame_scheduler
  import gpu_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
  parameter int unsigned TIMER_W      = DEFAULT_TIMER_W,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic             fb_ready_in,
  input  logic             matrix_valid_in,
  input  logic             pixel_valid_in,
  output logic             matrix_start_out,
  output logic             fetch_rst_out,
  output logic             fb_switch_out,
  output logic             fb_clear_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] pixel_count_out,
  output logic [CNT_W-1:0] frame_count_out
);

  sched_state_t state_q, state_d;
  logic         fetch_rst_q, fetch_rst_d;
  logic         matrix_start_q, matrix_start_d;
  logic         busy_q, busy_d;
  logic         tick;

  frame_timer #(
    .FRAME_PERIOD (FRAME_PERIOD),
    .TIMER_W      (TIMER_W)
  ) u_frame_timer (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .enable_in (enable_in),
    .tick_out  (tick)
  );

  // Next-state logic; dropping enable aborts before RUN but a running frame always completes
  always_comb begin
    state_d        = state_q;
    fetch_rst_d    = fetch_rst_q;
    matrix_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = WAIT_BUFFER;
      end
      WAIT_BUFFER: begin
        if (!enable_in) begin
          state_d = IDLE;
        end else if (fb_ready_in) begin
          state_d        = LOAD_MATRIX;
          matrix_start_d = 1'b1;
        end
      end
      LOAD_MATRIX: begin
        if (!enable_in) begin
          state_d = IDLE;
        end else if (matrix_valid_in) begin
          state_d     = RUN;
          fetch_rst_d = 1'b0;
        end
      end
      RUN: begin
        if (!fb_ready_in) begin
          fetch_rst_d = 1'b1;
          state_d     = enable_in ? WAIT_BUFFER : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        fetch_rst_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      fetch_rst_q    <= 1'b1;
      matrix_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_rst_q    <= fetch_rst_d;
      matrix_start_q <= matrix_start_d;
      busy_q         <= busy_d;
    end
  end

  assign matrix_start_out = matrix_start_q;
  assign fetch_rst_out    = fetch_rst_q;
  assign busy_out         = busy_q;
  assign fb_switch_out    = tick;
  assign fb_clear_out     = tick;

`ifdef FRAME_STATS_EN
  logic             start_frame_c, end_frame_c;
  logic [CNT_W-1:0] run_q, run_d, run_inc_c;
  logic [CNT_W-1:0] pix_q, pix_d, frames_q, frames_d;

  assign start_frame_c = (state_q == LOAD_MATRIX) && (state_d == RUN);
  assign end_frame_c   = (state_q == RUN) && !fb_ready_in;

  // Running count saturates; the closing cycle's pixel is folded into the published value
  always_comb begin
    run_inc_c = (pixel_valid_in && (run_q != {CNT_W{1'b1}})) ? run_q + CNT_W'(1) : run_q;
    run_d     = run_q;
    pix_d     = pix_q;
    frames_d  = frames_q;
    if (start_frame_c) begin
      run_d = '0;
    end else if (state_q == RUN) begin
      run_d = run_inc_c;
    end
    if (end_frame_c) begin
      pix_d    = run_inc_c;
      frames_d = frames_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_q    <= '0;
      pix_q    <= '0;
      frames_q <= '0;
    end else begin
      run_q    <= run_d;
      pix_q    <= pix_d;
      frames_q <= frames_d;
    end
  end

  assign pixel_count_out = pix_q;
  assign frame_count_out = frames_q;
`else
  logic unused_pixel_valid;
  assign unused_pixel_valid = pixel_valid_in;
  assign pixel_count_out    = '0;
  assign frame_count_out    = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: a 16-bit and a 4-bit counter instance share stimulus;
// end-of-frame results are scoreboarded and checked when fetch_rst_out rises.
module tb_frame_scheduler;

`ifdef FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int unsigned pix;
    int unsigned frames;
    int unsigned pix_s;
    int unsigned busy;
  } exp_t;

  logic clk = 1'b0;
  logic run_clk = 1'b0;
  logic rst_n, enable, fb_ready, matrix_valid, pixel_valid;

  logic        matrix_start, fetch_rst, fb_switch, fb_clear, busy;
  logic [15:0] pix, frames;
  logic        matrix_start_s, fetch_rst_s, fb_switch_s, fb_clear_s, busy_s;
  logic [3:0]  pix_s, frames_s;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        prev_fetch = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  frame_scheduler #(.FRAME_PERIOD(10), .TIMER_W(4), .CNT_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .fb_ready_in(fb_ready),
    .matrix_valid_in(matrix_valid), .pixel_valid_in(pixel_valid),
    .matrix_start_out(matrix_start), .fetch_rst_out(fetch_rst), .fb_switch_out(fb_switch),
    .fb_clear_out(fb_clear), .busy_out(busy), .pixel_count_out(pix), .frame_count_out(frames)
  );

  frame_scheduler #(.FRAME_PERIOD(10), .TIMER_W(4), .CNT_W(4)) dut_s (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .fb_ready_in(fb_ready),
    .matrix_valid_in(matrix_valid), .pixel_valid_in(pixel_valid),
    .matrix_start_out(matrix_start_s), .fetch_rst_out(fetch_rst_s), .fb_switch_out(fb_switch_s),
    .fb_clear_out(fb_clear_s), .busy_out(busy_s), .pixel_count_out(pix_s), .frame_count_out(frames_s)
  );

  initial forever begin
    #5;
    if (run_clk) clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int unsigned n_pix, input int unsigned n_frames,
                                  input int unsigned exp_busy);
    exp_t e;
    e.pix    = STATS ? n_pix : 0;
    e.frames = STATS ? n_frames : 0;
    e.pix_s  = STATS ? ((n_pix > 15) ? 15 : n_pix) : 0;
    e.busy   = exp_busy;
    return e;
  endfunction

  // End-of-frame monitor: every fetch_rst rise outside reset must match a queued expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fetch <= 1'b1;
    end else begin
      if (!prev_fetch && fetch_rst) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_end", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_pixel_count", 32'(pix), mon_e.pix);
          check_eq("sb_frame_count", 32'(frames), mon_e.frames);
          check_eq("sb_pixel_count_sat", 32'(pix_s), mon_e.pix_s);
          check_eq("sb_frame_count_small", 32'(frames_s), STATS ? mon_e.frames : 0);
          check_eq("sb_busy_after_end", 32'(busy), mon_e.busy);
        end
      end
      prev_fetch <= fetch_rst;
    end
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; fb_ready = 1'b0; matrix_valid = 1'b0; pixel_valid = 1'b0;

    // Asynchronous reset with the clock stopped
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_fetch_rst", 32'(fetch_rst), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_switch", 32'(fb_switch), 32'd0);
    check_eq("rst_clear", 32'(fb_clear), 32'd0);
    check_eq("rst_matrix_start", 32'(matrix_start), 32'd0);
    check_eq("rst_pixel_count", 32'(pix), 32'd0);
    check_eq("rst_frame_count", 32'(frames), 32'd0);
    #5 run_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Enable dropped in WAIT_BUFFER returns to IDLE
    enable = 1'b1;
    @(negedge clk);
    check_eq("wait_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_fetch_rst", 32'(fetch_rst), 32'd1);
    @(negedge clk);

    // Frame timer: pulses exactly at cycles 10, 20, 30 after enable
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check_eq($sformatf("switch_c%0d", k), 32'(fb_switch), 32'((k % 10) == 0));
      check_eq($sformatf("clear_c%0d", k), 32'(fb_clear), 32'((k % 10) == 0));
    end
    check_eq("timer_phase_busy", 32'(busy), 32'd1);

    // Buffer ready: single matrix_start pulse, pixels outside RUN ignored
    fb_ready = 1'b1;
    @(negedge clk);
    check_eq("matrix_start_pulse", 32'(matrix_start), 32'd1);
    check_eq("load_fetch_rst", 32'(fetch_rst), 32'd1);
    pixel_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("matrix_start_low", 32'(matrix_start), 32'd0);
      check_eq("load_fetch_rst_hold", 32'(fetch_rst), 32'd1);
    end
    pixel_valid  = 1'b0;
    matrix_valid = 1'b1;
    @(negedge clk);
    check_eq("run_fetch_rst", 32'(fetch_rst), 32'd0);
    check_eq("run_busy", 32'(busy), 32'd1);
    matrix_valid = 1'b0;

    // 100 pixels, 101st coincident with fb_ready fall
    pixel_valid = 1'b1;
    for (int i = 1; i < 100; i++) @(negedge clk);
    @(negedge clk);
    fb_ready = 1'b0;
    exp_q.push_back(mk_exp(101, 1, 1));
    @(negedge clk);
    pixel_valid = 1'b0;
    check_eq("eof1_fetch_rst", 32'(fetch_rst), 32'd1);
    @(negedge clk);

    // Matrix valid with matrix_start accepted; enable dropped mid-RUN finishes frame
    fb_ready = 1'b1;
    @(negedge clk);
    check_eq("matrix_start_pulse2", 32'(matrix_start), 32'd1);
    matrix_valid = 1'b1;
    @(negedge clk);
    check_eq("run2_fetch_rst", 32'(fetch_rst), 32'd0);
    matrix_valid = 1'b0;
    pixel_valid  = 1'b1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) enable = 1'b0;
    end
    @(negedge clk);
    check_eq("run2_still_running", 32'(fetch_rst), 32'd0);
    pixel_valid = 1'b0;
    fb_ready    = 1'b0;
    exp_q.push_back(mk_exp(20, 2, 0));
    @(negedge clk);
    check_eq("eof2_busy", 32'(busy), 32'd0);
    check_eq("eof2_fetch_rst", 32'(fetch_rst), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("timer_held_switch", 32'(fb_switch), 32'd0);
    end

    // Reset in the middle of a frame clears everything at once
    enable = 1'b1; fb_ready = 1'b1; matrix_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("run3_fetch_rst", 32'(fetch_rst), 32'd0);
    pixel_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_fetch_rst", 32'(fetch_rst), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_pixel_count", 32'(pix), 32'd0);
    check_eq("midrst_frame_count", 32'(frames), 32'd0);
    check_eq("midrst_pixel_count_small", 32'(pix_s), 32'd0);
    check_eq("midrst_matrix_start", 32'(matrix_start), 32'd0);
    enable = 1'b0; fb_ready = 1'b0; matrix_valid = 1'b0; pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_fetch_rst", 32'(fetch_rst), 32'd1);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
